// File: rtl/viterbi_bm_unit.sv
// Branch-metric stage of a rate-1/2, K=3 Viterbi decoder: takes c0/c1 soft bits serially and
// strobes out four branch metrics. Optional macro BM_NORM_EN subtracts the per-symbol minimum.
module viterbi_bm_unit #(
    parameter int unsigned SW        = 3,
    parameter int unsigned MW        = 8,
    parameter int unsigned FRAME_LEN = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          din_valid,
    input  logic [SW-1:0] din,
    output logic          din_ready,
    output logic          st,
    output logic [MW-1:0] bm00,
    output logic [MW-1:0] bm01,
    output logic [MW-1:0] bm10,
    output logic [MW-1:0] bm11,
    output logic [7:0]    sym_cnt,
    output logic          frame_done,
    output logic          busy
);

    if (MW < SW + 1) begin : g_mw_check
        $error("viterbi_bm_unit: MW (%0d) must be >= SW+1 (%0d)", MW, SW + 1);
    end

    if (FRAME_LEN < 1 || FRAME_LEN > 255) begin : g_len_check
        $error("viterbi_bm_unit: FRAME_LEN (%0d) must be in 1..255", FRAME_LEN);
    end

    localparam logic [7:0] FrameLenCnt = 8'(FRAME_LEN);

    typedef enum logic [1:0] {
        StIdle,
        StC0,
        StC1,
        StSym
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] c0_q, c0_d;
    logic [7:0]    sym_cnt_q, sym_cnt_d, sym_cnt_inc;
    logic          load_bm;
    logic [MW-1:0] bm00_q, bm01_q, bm10_q, bm11_q;

    assign sym_cnt_inc = sym_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        c0_d       = c0_q;
        sym_cnt_d  = sym_cnt_q;
        din_ready  = 1'b0;
        st         = 1'b0;
        frame_done = 1'b0;
        load_bm    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d   = StC0;
                    sym_cnt_d = 8'd0;
                end
            end
            StC0: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    c0_d    = din;
                    state_d = StC1;
                end
            end
            StC1: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    load_bm = 1'b1;
                    state_d = StSym;
                end
            end
            StSym: begin
                st        = 1'b1;
                sym_cnt_d = sym_cnt_inc;
                if (sym_cnt_inc == FrameLenCnt) begin
                    frame_done = 1'b1;
                    state_d    = StIdle;
                end else begin
                    state_d = StC0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // For an SW-bit value, (2^SW-1)-x is simply ~x.
    logic [SW-1:0] c0_inv, c1_inv;
    logic [SW:0]   raw00, raw01, raw10, raw11;
    logic [SW:0]   nrm00, nrm01, nrm10, nrm11;

    assign c0_inv = ~c0_q;
    assign c1_inv = ~din;

    assign raw00 = {1'b0, c0_q}   + {1'b0, din};
    assign raw01 = {1'b0, c0_q}   + {1'b0, c1_inv};
    assign raw10 = {1'b0, c0_inv} + {1'b0, din};
    assign raw11 = {1'b0, c0_inv} + {1'b0, c1_inv};

`ifdef BM_NORM_EN
    logic [SW:0] min_a, min_b, min_all;

    assign min_a   = (raw00 < raw01) ? raw00 : raw01;
    assign min_b   = (raw10 < raw11) ? raw10 : raw11;
    assign min_all = (min_a < min_b) ? min_a : min_b;

    assign nrm00 = raw00 - min_all;
    assign nrm01 = raw01 - min_all;
    assign nrm10 = raw10 - min_all;
    assign nrm11 = raw11 - min_all;
`else
    assign nrm00 = raw00;
    assign nrm01 = raw01;
    assign nrm10 = raw10;
    assign nrm11 = raw11;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            c0_q      <= '0;
            sym_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            c0_q      <= c0_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end

    // Metrics persist across frames until the next c1 transfer overwrites them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bm00_q <= '0;
            bm01_q <= '0;
            bm10_q <= '0;
            bm11_q <= '0;
        end else if (load_bm) begin
            bm00_q <= MW'(nrm00);
            bm01_q <= MW'(nrm01);
            bm10_q <= MW'(nrm10);
            bm11_q <= MW'(nrm11);
        end
    end

    assign bm00    = bm00_q;
    assign bm01    = bm01_q;
    assign bm10    = bm10_q;
    assign bm11    = bm11_q;
    assign sym_cnt = sym_cnt_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_viterbi_bm_unit.sv
// Self-checking bench for viterbi_bm_unit: randomized soft-bit streams against a metric model.
module tb_viterbi_bm_unit;

    localparam int SW        = 3;
    localparam int MW        = 8;
    localparam int FRAME_LEN = 20;
    localparam int MAXS      = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_start = 1'b0;
    logic          din_valid = 1'b0;
    logic [SW-1:0] din = '0;
    logic          din_ready, st, frame_done, busy;
    logic [MW-1:0] bm00, bm01, bm10, bm11;
    logic [7:0]    sym_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_bm[4];
    int tx_bits[$];

    viterbi_bm_unit #(
        .SW       (SW),
        .MW       (MW),
        .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .st         (st),
        .bm00       (bm00),
        .bm01       (bm01),
        .bm10       (bm10),
        .bm11       (bm11),
        .sym_cnt    (sym_cnt),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        frame_start = 1'b0;
        din_valid = 1'b0;
        #4;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) exp_bm[k] = 0;
    endtask

    task automatic begin_frame();
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        din_valid = 1'b0;
    endtask

    task automatic fill_random(input int nsym);
        tx_bits.delete();
        for (int i = 0; i < 2 * nsym; i++) tx_bits.push_back(int'($urandom_range(MAXS)));
    endtask

    // Drives tx_bits as nsym symbols and checks every cycle against the metric model.
    task automatic stream(input int nsym, input int stall_pct, input bit fs_noise,
                          input bit gap_chk);
        int exp_q[$];
        int got[4];
        int m[4];
        int mn;
        int bi = 0, emitted = 0, cyc = 0, last_st = -1, post = 0, c0v = 0, c1v = 0;
        bit exp_st = 1'b0;
        while (post < 3) begin
            @(posedge clk);
            #1;
            cyc++;
            frame_start = (fs_noise && emitted < nsym) ? 1'($urandom_range(1)) : 1'b0;
            if (!din_ready) begin
                din_valid = 1'($urandom_range(1));
                din = SW'($urandom);
            end else if (bi < 2 * nsym && int'($urandom_range(99)) >= stall_pct) begin
                din_valid = 1'b1;
                din = SW'(tx_bits[bi]);
            end else begin
                din_valid = 1'b0;
                din = SW'($urandom);
            end
            @(negedge clk);
            got[0] = int'(bm00); got[1] = int'(bm01); got[2] = int'(bm10); got[3] = int'(bm11);
            n_checks++;
            if (st !== exp_st) $display("FAIL st_timing: cyc %0d st=%b want %b", cyc, st, exp_st);
            else n_pass++;
            if (exp_st) begin
                n_checks++;
                if (din_ready !== 1'b0) $display("FAIL ready_in_st: got %b want 0", din_ready);
                else n_pass++;
                for (int k = 0; k < 4; k++) begin
                    exp_bm[k] = exp_q.pop_front();
                    n_checks++;
                    if (got[k] !== exp_bm[k])
                        $display("FAIL bm%0d%0d sym %0d: got %0d want %0d",
                                 k >> 1, k & 1, emitted, got[k], exp_bm[k]);
                    else n_pass++;
                end
                emitted++;
                n_checks++;
                if (frame_done !== (emitted == FRAME_LEN))
                    $display("FAIL frame_done sym %0d: got %b want %b",
                             emitted, frame_done, emitted == FRAME_LEN);
                else n_pass++;
                if (gap_chk && last_st >= 0) begin
                    n_checks++;
                    if (cyc - last_st != 3)
                        $display("FAIL st_gap: got %0d cycles want 3", cyc - last_st);
                    else n_pass++;
                end
                last_st = cyc;
            end else begin
                n_checks++;
                if (frame_done !== 1'b0) $display("FAIL frame_done_idle: got %b want 0",
                                                  frame_done);
                else n_pass++;
                for (int k = 0; k < 4; k++) begin
                    n_checks++;
                    if (got[k] !== exp_bm[k])
                        $display("FAIL bm_hold%0d: got %0d want %0d", k, got[k], exp_bm[k]);
                    else n_pass++;
                end
                n_checks++;
                if (sym_cnt !== 8'(emitted))
                    $display("FAIL sym_cnt: got %0d want %0d", sym_cnt, emitted);
                else n_pass++;
                n_checks++;
                if (busy !== (emitted < nsym || nsym < FRAME_LEN))
                    $display("FAIL busy: got %b want %b", busy, emitted < nsym || nsym < FRAME_LEN);
                else n_pass++;
                if (emitted == nsym) begin
                    n_checks++;
                    if (din_ready !== (nsym < FRAME_LEN))
                        $display("FAIL ready_after: got %b want %b", din_ready, nsym < FRAME_LEN);
                    else n_pass++;
                end
            end
            exp_st = 1'b0;
            if (din_valid && din_ready) begin
                if (bi % 2 == 0) begin
                    c0v = tx_bits[bi];
                end else begin
                    c1v = tx_bits[bi];
                    for (int k = 0; k < 4; k++)
                        m[k] = (((k >> 1) != 0) ? MAXS - c0v : c0v) +
                               (((k & 1) != 0) ? MAXS - c1v : c1v);
`ifdef BM_NORM_EN
                    mn = m[0];
                    for (int k = 1; k < 4; k++) if (m[k] < mn) mn = m[k];
                    for (int k = 0; k < 4; k++) m[k] = m[k] - mn;
`else
                    mn = 0;
`endif
                    for (int k = 0; k < 4; k++) exp_q.push_back(m[k]);
                    exp_st = 1'b1;
                end
                bi++;
            end
            if (emitted == nsym && !exp_st) post++;
            if (cyc > 2000) begin
                n_checks++;
                $display("FAIL stream_timeout: emitted %0d want %0d", emitted, nsym);
                break;
            end
        end
        din_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({din_ready, st, frame_done, busy, sym_cnt, bm00, bm01, bm10, bm11} !== '0)
            $display("FAIL reset_initial: got busy=%b ready=%b st=%b", busy, din_ready, st);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) exp_bm[k] = 0;
        begin_frame();
        tx_bits = '{1, 6};
        stream(1, 0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #2;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++;
        if (din_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", din_ready);
        else n_pass++;
        n_checks++;
        if ({st, frame_done} !== 2'b00) $display("FAIL reset_st: got %b want 00",
                                                  {st, frame_done});
        else n_pass++;
        n_checks++;
        if (sym_cnt !== 8'd0) $display("FAIL reset_symcnt: got %0d want 0", sym_cnt);
        else n_pass++;
        n_checks++;
        if ({bm00, bm01, bm10, bm11} !== '0)
            $display("FAIL reset_bm: got %0d %0d %0d %0d want 0", bm00, bm01, bm10, bm11);
        else n_pass++;
        #2;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) exp_bm[k] = 0;
    endtask

    task automatic test_single();
        do_reset();
        begin_frame();
        tx_bits = '{0, 7};
        stream(1, 0, 1'b0, 1'b0);
        n_checks++;
        if ({bm00, bm01, bm10, bm11} !== {8'd7, 8'd0, 8'd14, 8'd7})
            $display("FAIL single_bm: got %0d %0d %0d %0d want 7 0 14 7",
                     bm00, bm01, bm10, bm11);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_soft();
        logic [4*MW-1:0] want;
`ifdef BM_NORM_EN
        want = {8'd1, 8'd0, 8'd2, 8'd1};
`else
        want = {8'd7, 8'd6, 8'd8, 8'd7};
`endif
        do_reset();
        begin_frame();
        tx_bits = '{3, 4};
        stream(1, 30, 1'b0, 1'b0);
        n_checks++;
        if ({bm00, bm01, bm10, bm11} !== want)
            $display("FAIL soft_bm: got %0d %0d %0d %0d want %h", bm00, bm01, bm10, bm11, want);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_full_frame();
        do_reset();
        begin_frame();
        fill_random(FRAME_LEN);
        stream(FRAME_LEN, 0, 1'b0, 1'b1);
    endtask

    task automatic test_stalls();
        begin_frame();
        fill_random(FRAME_LEN);
        stream(FRAME_LEN, 45, 1'b0, 1'b0);
    endtask

    task automatic test_frame_start_mid();
        begin_frame();
        fill_random(FRAME_LEN);
        stream(FRAME_LEN, 20, 1'b1, 1'b0);
    endtask

    task automatic test_rst_mid();
        begin_frame();
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        din_valid = 1'b1;
        din = SW'(5);
        @(negedge clk);
        n_checks++;
        if (din_ready !== 1'b1) $display("FAIL rstmid_ready_c0: got %b want 1", din_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        #1;
        rst = 1'b0;
        #2;
        n_checks++;
        if ({busy, din_ready, sym_cnt} !== 10'd0)
            $display("FAIL rstmid_state: got busy=%b ready=%b cnt=%0d want 0 0 0",
                     busy, din_ready, sym_cnt);
        else n_pass++;
        #2;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) exp_bm[k] = 0;
        begin_frame();
        fill_random(1);
        stream(1, 0, 1'b0, 1'b0);
        do_reset();
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            begin_frame();
            fill_random(FRAME_LEN);
            stream(FRAME_LEN, 10, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_soft();
        test_full_frame();
        test_stalls();
        test_frame_start_mid();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
